// File: rtl/pst_mem.sv
// Memory-access stage: one data-memory transaction per instruction over req/ack.
// Formats load data and store lanes, stalls upstream while waiting, and
// aborts unacknowledged transactions with a watchdog.
//
// Ports:
//   clk, rst         rising-edge clock, async active-high reset
//   en, in_valid     accept qualifiers from hazard control / upstream
//   alu_data_res     address for loads/stores, pass-through data otherwise
//   rf_data_b        store data
//   ctl_mem_op       0 NONE,1 LW,2 LH,3 LHU,4 LB,5 LBU,6 SW,7 SH,8 SB
//   stall            high while a transaction is outstanding
//   dm_*             data-memory request interface (registered)
//   out_valid/out_data/err  one-cycle result pulse with error flag
module pst_mem #(
    parameter int unsigned DM_ADDR_BIT = 10,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [31:0]            alu_data_res,
    input  logic [31:0]            rf_data_b,
    input  logic [3:0]             ctl_mem_op,
    output logic                   stall,
    output logic                   dm_req,
    output logic                   dm_we,
    output logic [DM_ADDR_BIT-1:0] dm_addr,
    output logic [3:0]             dm_be,
    output logic [31:0]            dm_wdata,
    input  logic                   dm_ack,
    input  logic [31:0]            dm_rdata,
    output logic                   out_valid,
    output logic [31:0]            out_data,
    output logic                   err
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic                   dm_req_q, dm_req_d;
    logic                   dm_we_q, dm_we_d;
    logic [DM_ADDR_BIT-1:0] dm_addr_q, dm_addr_d;
    logic [3:0]             dm_be_q, dm_be_d;
    logic [31:0]            dm_wdata_q, dm_wdata_d;
    logic [3:0]             op_q, op_d;
    logic [1:0]             off_q, off_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_data_q, out_data_d;
    logic                   err_q, err_d;

    logic                   is_load;
    logic                   is_store;
    logic                   misal;
    logic [3:0]             st_be;
    logic [31:0]            st_wdata;
    logic [7:0]             lane_b;
    logic [15:0]            lane_h;
    logic [31:0]            ld_data;

    // Request decode from the live inputs (used only at accept).
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misal    = 1'b0;
        st_be    = 4'b1111;
        st_wdata = 32'd0;
        case (ctl_mem_op)
            OP_LW: begin
                is_load = 1'b1;
                misal   = (alu_data_res[1:0] != 2'b00);
            end
            OP_LH, OP_LHU: begin
                is_load = 1'b1;
                misal   = alu_data_res[0];
            end
            OP_LB, OP_LBU: begin
                is_load = 1'b1;
            end
            OP_SW: begin
                is_store = 1'b1;
                misal    = (alu_data_res[1:0] != 2'b00);
                st_wdata = rf_data_b;
            end
            OP_SH: begin
                is_store = 1'b1;
                misal    = alu_data_res[0];
                st_be    = alu_data_res[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rf_data_b[15:0]}};
            end
            OP_SB: begin
                is_store = 1'b1;
                st_be    = 4'b0001 << alu_data_res[1:0];
                st_wdata = {4{rf_data_b[7:0]}};
            end
            default: begin
                is_load  = 1'b0;
                is_store = 1'b0;
            end
        endcase
    end

    // Load lane extraction from the saved byte offset.
    always_comb begin
        lane_b = dm_rdata[7:0];
        case (off_q)
            2'd1:    lane_b = dm_rdata[15:8];
            2'd2:    lane_b = dm_rdata[23:16];
            2'd3:    lane_b = dm_rdata[31:24];
            default: lane_b = dm_rdata[7:0];
        endcase
        lane_h  = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        ld_data = 32'd0;
        case (op_q)
            OP_LW:   ld_data = dm_rdata;
            OP_LH:   ld_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  ld_data = {16'd0, lane_h};
            OP_LB:   ld_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  ld_data = {24'd0, lane_b};
            default: ld_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_be_d     = dm_be_q;
        dm_wdata_d  = dm_wdata_q;
        op_d        = op_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (en && in_valid) begin
                    if (!is_load && !is_store) begin
                        out_valid_d = 1'b1;
                        out_data_d  = alu_data_res;
                        err_d       = 1'b0;
                    end else if (misal) begin
                        out_valid_d = 1'b1;
                        out_data_d  = 32'd0;
                        err_d       = 1'b1;
                    end else begin
                        state_d    = S_WAIT;
                        dm_req_d   = 1'b1;
                        dm_we_d    = is_store;
                        dm_addr_d  = alu_data_res[DM_ADDR_BIT+1:2];
                        dm_be_d    = st_be;
                        dm_wdata_d = st_wdata;
                        op_d       = ctl_mem_op;
                        off_d      = alu_data_res[1:0];
                        cnt_d      = 32'd0;
                    end
                end
            end
            S_WAIT: begin
                // Ack wins over a coincident timeout.
                if (dm_ack && dm_req_q) begin
                    state_d     = S_IDLE;
                    dm_req_d    = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = ld_data;
                    err_d       = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt_q + 32'd1 == TIMEOUT)) begin
                    state_d     = S_IDLE;
                    dm_req_d    = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = 32'd0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_be_q     <= 4'd0;
            dm_wdata_q  <= 32'd0;
            op_q        <= 4'd0;
            off_q       <= 2'd0;
            cnt_q       <= 32'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_be_q     <= dm_be_d;
            dm_wdata_q  <= dm_wdata_d;
            op_q        <= op_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign stall     = (state_q == S_WAIT);
    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_be     = dm_be_q;
    assign dm_wdata  = dm_wdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pst_mem.sv
// Directed bench for pst_mem: pass-through, loads, stores, misalignment,
// watchdog timeout and asynchronous reset during a transaction.
module tb_pst_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [31:0] alu_data_res;
    logic [31:0] rf_data_b;
    logic [3:0]  ctl_mem_op;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic        cap_req;
    logic        cap_we;
    logic [9:0]  cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    int          stall_cnt;

    pst_mem #(.DM_ADDR_BIT(10), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .alu_data_res(alu_data_res), .rf_data_b(rf_data_b),
        .ctl_mem_op(ctl_mem_op), .stall(stall), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .out_valid(out_valid), .out_data(out_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one memory op; n_wait WAIT cycles, ack in the last one if ack=1.
    // Returns at the negedge after the completing edge.
    task automatic run_mem(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] rd,
                           input int n_wait, input bit ack);
        en = 1'b1; in_valid = 1'b1;
        ctl_mem_op = op; alu_data_res = a; rf_data_b = b;
        stall_cnt = 0;
        @(negedge clk);
        for (int c = 1; c <= n_wait; c++) begin
            if (stall) stall_cnt++;
            if (c == 1) begin
                cap_req = dm_req; cap_we = dm_we; cap_addr = dm_addr;
                cap_be = dm_be; cap_wdata = dm_wdata;
            end
            if (c == n_wait) begin
                in_valid = 1'b0;
                if (ack) begin
                    dm_ack = 1'b1; dm_rdata = rd;
                end
            end
            @(negedge clk);
        end
        dm_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0;
        alu_data_res = 0; rf_data_b = 0; ctl_mem_op = 0;
        dm_ack = 1'b0; dm_rdata = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_be", {28'd0, dm_be}, 32'd0);

        // NONE pass-through, three back-to-back
        en = 1'b1; in_valid = 1'b1; ctl_mem_op = 4'd0;
        alu_data_res = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("none_ov", {31'd0, out_valid}, 32'd1);
            chk("none_data", out_data, 32'h1234_5678);
            chk("none_stall", {31'd0, stall}, 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("none_ov_drop", {31'd0, out_valid}, 32'd0);

        // en=0 blocks accept
        en = 1'b0; in_valid = 1'b1; alu_data_res = 32'hAAAA_0000;
        @(negedge clk);
        chk("en0_ov", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;

        // LB 0x7, ack in third WAIT cycle
        run_mem(4'd4, 32'h7, 32'h0, 32'h80FF_1234, 3, 1'b1);
        chk("lb_req", {31'd0, cap_req}, 32'd1);
        chk("lb_addr", {22'd0, cap_addr}, 32'd1);
        chk("lb_be", {28'd0, cap_be}, 32'hF);
        chk("lb_we", {31'd0, cap_we}, 32'd0);
        chk("lb_stall_cnt", stall_cnt, 32'd3);
        chk("lb_ov", {31'd0, out_valid}, 32'd1);
        chk("lb_data", out_data, 32'hFFFF_FF80);
        chk("lb_err", {31'd0, err}, 32'd0);
        chk("lb_stall_end", {31'd0, stall}, 32'd0);
        chk("lb_req_end", {31'd0, dm_req}, 32'd0);
        @(negedge clk);
        chk("lb_ov_pulse", {31'd0, out_valid}, 32'd0);

        run_mem(4'd5, 32'h7, 32'h0, 32'h80FF_1234, 3, 1'b1);
        chk("lbu_data", out_data, 32'h0000_0080);

        // SH 0x2, immediate ack
        run_mem(4'd7, 32'h2, 32'h0000_BEEF, 32'h0, 1, 1'b1);
        chk("sh_we", {31'd0, cap_we}, 32'd1);
        chk("sh_be", {28'd0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("sh_ov", {31'd0, out_valid}, 32'd1);
        chk("sh_err", {31'd0, err}, 32'd0);
        chk("sh_data", out_data, 32'd0);

        // SB 0x6
        run_mem(4'd8, 32'h6, 32'h0000_00A5, 32'h0, 2, 1'b1);
        chk("sb_be", {28'd0, cap_be}, 32'h4);
        chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", {22'd0, cap_addr}, 32'd1);

        // LH / LHU upper half
        run_mem(4'd2, 32'h2, 32'h0, 32'h8001_7FFF, 1, 1'b1);
        chk("lh_data", out_data, 32'hFFFF_8001);
        run_mem(4'd3, 32'h2, 32'h0, 32'h8001_7FFF, 1, 1'b1);
        chk("lhu_data", out_data, 32'h0000_8001);

        // Misaligned LW
        en = 1'b1; in_valid = 1'b1; ctl_mem_op = 4'd1; alu_data_res = 32'h5;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mis_req", {31'd0, dm_req}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        chk("mis_ov", {31'd0, out_valid}, 32'd1);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_data", out_data, 32'd0);

        // Watchdog timeout (TIMEOUT=4)
        run_mem(4'd1, 32'h40, 32'h0, 32'h0, 4, 1'b0);
        chk("to_stall_cnt", stall_cnt, 32'd4);
        chk("to_req", {31'd0, dm_req}, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd0);
        chk("to_ov", {31'd0, out_valid}, 32'd1);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_data", out_data, 32'd0);

        // Ack in the 4th WAIT cycle beats the timeout
        run_mem(4'd1, 32'h40, 32'h0, 32'hCAFE_F00D, 4, 1'b1);
        chk("late_ov", {31'd0, out_valid}, 32'd1);
        chk("late_err", {31'd0, err}, 32'd0);
        chk("late_data", out_data, 32'hCAFE_F00D);

        // Reset during WAIT
        en = 1'b1; in_valid = 1'b1; ctl_mem_op = 4'd1; alu_data_res = 32'h10;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rw_req_before", {31'd0, dm_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rw_req_async", {31'd0, dm_req}, 32'd0);
        chk("rw_stall_async", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rw_ov", {31'd0, out_valid}, 32'd0);
        run_mem(4'd1, 32'h10, 32'h0, 32'h1122_3344, 2, 1'b1);
        chk("rw_next_data", out_data, 32'h1122_3344);
        chk("rw_next_err", {31'd0, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
